// File: rtl/pll_adda_dyn_ctrl.sv
// ---------------------------------------------------------------------------
// PllAddaDynCtrl -- dynamic PLL loop tuning controller
//
// Walks a four-entry table of charge-pump / loop-filter presets. For each
// preset it pulses the PLL reset, waits for lock, and demands an unbroken
// run of lock samples before declaring the PLL locked. When every preset
// has been tried without success it parks in a fail state until restarted.
//
// Optional feature macro: PLL_ADDA_LOSS_MON_EN
//   defined   -> a lock loss while locked is counted (saturating) and
//                tuning restarts from preset 0
//   undefined -> the locked state ignores the lock input and relock_cnt_o
//                stays 0
//
// Ports
//   clkin_i       controller clock, all logic on its rising edge
//   reset_i       synchronous active-high reset
//   start_i       single-cycle pulse, restart tuning from preset 0
//   pll_lock_i    PLL lock flag, asynchronous to clkin_i
//   pll_reset_o   PLL reset, active-high
//   pll_icpsel_o  charge-pump current select
//   pll_lpfres_o  loop-filter resistor select
//   pll_lpfcap_o  loop-filter capacitor select
//   locked_o      high while locked
//   fail_o        high while every preset has failed
//   entry_idx_o   index of the preset currently applied
//   relock_cnt_o  saturating count of lock-loss events
// ---------------------------------------------------------------------------
module pll_adda_dyn_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       clkin_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic [5:0] pll_icpsel_o,
  output logic [2:0] pll_lpfres_o,
  output logic [1:0] pll_lpfcap_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [1:0] entry_idx_o,
  output logic [7:0] relock_cnt_o
);

  typedef enum logic [2:0] {
    ST_APPLY,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  // Terminal counts: each phase lasts until the counter reaches count-1.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  entry_q, entry_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  relock_q, relock_d;
  logic [5:0]  icp_q, icp_d;
  logic [2:0]  res_q, res_d;
  logic [1:0]  cap_q, cap_d;
  logic        pll_reset_q, pll_reset_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic        sync1_q, sync2_q;
  logic        lock_s;
  logic        advance;

  assign lock_s = sync2_q;

  // All state, including the lock synchronizer, lives here.
  always_ff @(posedge clkin_i) begin
    if (reset_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_APPLY;
      entry_q     <= 2'd0;
      cnt_q       <= 16'd0;
      relock_q    <= 8'd0;
      icp_q       <= 6'd16;
      res_q       <= 3'd2;
      cap_q       <= 2'd0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= pll_lock_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      relock_q    <= relock_d;
      icp_q       <= icp_d;
      res_q       <= res_d;
      cap_q       <= cap_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic. The shared counter is zeroed on every state change so
  // each phase measures its own duration; start overrides everything.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q + 16'd1;
    relock_d = relock_q;
    advance  = 1'b0;

    if (start_i) begin
      state_d = ST_APPLY;
      entry_d = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_APPLY: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = 16'd0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = 16'd0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            advance = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            advance = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = 16'd0;
          end
        end
        ST_LOCKED: begin
          cnt_d = cnt_q;
`ifdef PLL_ADDA_LOSS_MON_EN
          if (!lock_s) begin
            if (relock_q != 8'hFF) begin
              relock_d = relock_q + 8'd1;
            end
            state_d = ST_APPLY;
            entry_d = 2'd0;
            cnt_d   = 16'd0;
          end
`endif
        end
        ST_FAIL: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_APPLY;
          entry_d = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase

      // Current preset gave up: try the next one, or fail after the last.
      if (advance) begin
        cnt_d = 16'd0;
        if (entry_q == 2'd3) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_APPLY;
          entry_d = entry_q + 2'd1;
        end
      end
    end
  end

  // Registered outputs. The preset registers load only when APPLY is
  // (re)entered, so they change together with pll_reset going high.
  always_comb begin
    pll_reset_d = (state_d == ST_APPLY);
    locked_d    = (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
    icp_d       = icp_q;
    res_d       = res_q;
    cap_d       = cap_q;
    if (state_d == ST_APPLY) begin
      case (entry_d)
        2'd0:    begin icp_d = 6'd16; res_d = 3'd2; cap_d = 2'd0; end
        2'd1:    begin icp_d = 6'd24; res_d = 3'd3; cap_d = 2'd0; end
        2'd2:    begin icp_d = 6'd32; res_d = 3'd4; cap_d = 2'd1; end
        default: begin icp_d = 6'd40; res_d = 3'd5; cap_d = 2'd1; end
      endcase
    end
  end

  assign pll_reset_o  = pll_reset_q;
  assign pll_icpsel_o = icp_q;
  assign pll_lpfres_o = res_q;
  assign pll_lpfcap_o = cap_q;
  assign locked_o     = locked_q;
  assign fail_o       = fail_q;
  assign entry_idx_o  = entry_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: doc/pll_adda_dyn_ctrl.md
PLL_ADDA_DYN_CTRL -- requirements
Module: pll_adda_dyn_ctrl

Interface
REQ-001 Parameter RST_CYCLES, 16: PLL reset pulse width in clkin cycles (>=2).
REQ-002 Parameter LOCK_TIMEOUT, 65535: maximum clkin cycles to wait for lock per preset (16-bit).
REQ-003 Parameter STABLE_CYCLES, 1024: consecutive synchronized lock-high cycles required before declaring lock (>=1).
REQ-004 clkin  input  1  controller clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse: restart tuning from preset 0.
REQ-007 pll_lock  input  1  PLL lock; asynchronous to clkin.
REQ-008 pll_reset  output  1  PLL reset, active-high.
REQ-009 pll_icpsel  output  6  dynamic charge-pump current select.
REQ-010 pll_lpfres  output  3  dynamic loop-filter resistor select.
REQ-011 pll_lpfcap  output  2  dynamic loop-filter capacitor select.
REQ-012 locked  output  1  high while state is LOCKED.
REQ-013 fail  output  1  high while state is FAIL.
REQ-014 entry_idx  output  2  index of the preset currently applied.
REQ-015 relock_cnt  output  8  number of lock-loss events, saturating.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer; lock_s denotes the second-flop output, and all decisions SHALL use lock_s only.
REQ-017 Preset table (icpsel, lpfres, lpfcap) SHALL be: 0=(16,2,0), 1=(24,3,0), 2=(32,4,1), 3=(40,5,1).
REQ-018 pll_icpsel/pll_lpfres/pll_lpfcap SHALL be registered; they SHALL change only on the first APPLY cycle, while pll_reset is already high.
REQ-019 States: APPLY, WAIT_LOCK, STABLE, LOCKED, FAIL.
REQ-020 APPLY: pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with pll_reset=0.
REQ-021 WAIT_LOCK: lock_s=1 -> STABLE; no lock_s within LOCK_TIMEOUT cycles -> next preset.
REQ-022 STABLE: STABLE_CYCLES consecutive cycles of lock_s=1 -> LOCKED; locked SHALL assert on the cycle after the STABLE_CYCLES-th high sample.
REQ-023 STABLE: any lock_s=0 -> next preset.
REQ-024 Next preset: if entry_idx<3, increment entry_idx and go to APPLY; if entry_idx==3, go to FAIL with pll_reset=0.
REQ-025 FAIL and LOCKED SHALL hold until start, reset, or (LOCKED only, with macro) lock loss.
REQ-026 start in any state SHALL go to APPLY with entry_idx=0 on the next cycle, clearing locked and fail; relock_cnt SHALL be preserved.
REQ-027 reset and start asserted together: reset wins.
REQ-028 Timeout and stable counters SHALL clear on every state entry.

Reset
REQ-029 On reset the block SHALL enter APPLY with entry_idx=0, pll_reset=1, preset 0 on the PLL outputs, locked=0, fail=0, relock_cnt=0, counters=0, and synchronizer flops=0.
REQ-030 pll_reset SHALL stay high during reset and for RST_CYCLES cycles after reset deasserts.

Configuration
REQ-031 Macro PLL_ADDA_LOSS_MON_EN defined: in LOCKED, lock_s=0 SHALL increment relock_cnt (saturating at 255) and go to APPLY with entry_idx=0.
REQ-032 Macro PLL_ADDA_LOSS_MON_EN undefined: LOCKED SHALL ignore lock_s, and relock_cnt SHALL be constant 0.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8)
REQ-033 Release reset, pll_lock=1 constantly -> pll_reset high for 4 cycles after reset, icpsel=16, locked asserts with entry_idx=0, fail=0.
REQ-034 pll_lock=0 until entry 2 is applied, then 1 -> entry_idx steps 0,1,2, with a 4-cycle pll_reset pulse and new icp/res/cap values (24,3,0 then 32,4,1) each time; locked with entry_idx=2.
REQ-035 pll_lock=0 constantly -> after four 100-cycle timeouts fail=1, entry_idx=3, pll_reset=0; a start pulse then produces entry_idx=0, fail=0, and pll_reset high for 4 cycles.
REQ-036 Lock glitches low for 1 cycle after 5 high cycles in STABLE -> move to the next preset, no locked pulse.
REQ-037 With macro, drop pll_lock in LOCKED -> relock_cnt=1, re-tune from entry 0; without macro, locked stays 1 and relock_cnt=0.
REQ-038 start and reset asserted in the same cycle during WAIT_LOCK -> reset values as in REQ-029 (relock_cnt=0).
